// File: rtl/grn_node_multi.sv
// Gene-regulatory-network node with two independent simulation copies (s0, s1).
// Each copy steps its multi-level state from its regulators; s0 evaluates on every DIV-th strobe.
module grn_node_multi #(
    parameter int STATE_W = 1,
    parameter int NUM_IN  = 4,
    parameter int DIV     = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      reset_nos,
    input  logic                      start_s0,
    input  logic                      start_s1,
    input  logic [STATE_W-1:0]        init_state,
    input  logic [NUM_IN*STATE_W-1:0] in_s0,
    input  logic [NUM_IN*STATE_W-1:0] in_s1,
    input  logic [NUM_IN-1:0]         act_mask,
    input  logic [NUM_IN-1:0]         inh_mask,
    output logic [STATE_W-1:0]        s0,
    output logic [STATE_W-1:0]        s1,
    output logic                      changed_s0,
    output logic                      changed_s1,
    output logic [CNT_W-1:0]          stable_s0,
    output logic [CNT_W-1:0]          stable_s1
);

    localparam int                 CNT_A_W = $clog2(NUM_IN + 1);
    localparam int                 PH_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PH_W-1:0]    PH_LAST = PH_W'(DIV - 1);
    localparam logic [STATE_W-1:0] ST_MAX  = {STATE_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

    // Saturating activate/inhibit step: compare counts of active activators and inhibitors.
    function automatic logic [STATE_W-1:0] f_next(
        input logic [NUM_IN*STATE_W-1:0] regs,
        input logic [STATE_W-1:0]        cur,
        input logic [NUM_IN-1:0]         am,
        input logic [NUM_IN-1:0]         im
    );
        logic [CNT_A_W-1:0] a;
        logic [CNT_A_W-1:0] h;
        a = '0;
        h = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (am[i] && (regs[i*STATE_W +: STATE_W] != '0)) a = a + CNT_A_W'(1);
            if (im[i] && (regs[i*STATE_W +: STATE_W] != '0)) h = h + CNT_A_W'(1);
        end
        if (a > h)      f_next = (cur == ST_MAX) ? cur : cur + STATE_W'(1);
        else if (h > a) f_next = (cur == '0)     ? cur : cur - STATE_W'(1);
        else            f_next = cur;
    endfunction

    function automatic logic [CNT_W-1:0] f_stable(input logic chg, input logic [CNT_W-1:0] cnt);
        if (chg)                 f_stable = '0;
        else if (cnt == CNT_MAX) f_stable = cnt;
        else                     f_stable = cnt + CNT_W'(1);
    endfunction

    logic [STATE_W-1:0] r_s0, r_s1;
    logic               r_changed_s0, r_changed_s1;
    logic [CNT_W-1:0]   r_stable_s0, r_stable_s1;
    logic [PH_W-1:0]    r_ph;

    logic [STATE_W-1:0] w_next_s0, w_next_s1;
    logic               w_eval_s0;
    logic               w_chg_s0, w_chg_s1;

    always_comb begin
        w_next_s0 = f_next(in_s0, r_s0, act_mask, inh_mask);
        w_next_s1 = f_next(in_s1, r_s1, act_mask, inh_mask);
        w_eval_s0 = start_s0 && (r_ph == '0);
        w_chg_s0  = (w_next_s0 != r_s0);
        w_chg_s1  = (w_next_s1 != r_s1);
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0         <= '0;
            r_s1         <= '0;
            r_changed_s0 <= 1'b0;
            r_changed_s1 <= 1'b0;
            r_stable_s0  <= '0;
            r_stable_s1  <= '0;
            r_ph         <= '0;
        end else if (reset_nos) begin
            r_s0         <= init_state;
            r_s1         <= init_state;
            r_changed_s0 <= 1'b0;
            r_changed_s1 <= 1'b0;
            r_stable_s0  <= '0;
            r_stable_s1  <= '0;
            r_ph         <= '0;
        end else begin
            // Change flags are single-cycle pulses; only an evaluation raises them.
            r_changed_s0 <= 1'b0;
            r_changed_s1 <= 1'b0;
            if (w_eval_s0) begin
                r_s0         <= w_next_s0;
                r_changed_s0 <= w_chg_s0;
                r_stable_s0  <= f_stable(w_chg_s0, r_stable_s0);
            end
            if (start_s0) begin
                r_ph <= (r_ph == PH_LAST) ? '0 : r_ph + PH_W'(1);
            end
            if (start_s1) begin
                r_s1         <= w_next_s1;
                r_changed_s1 <= w_chg_s1;
                r_stable_s1  <= f_stable(w_chg_s1, r_stable_s1);
            end
        end
    end

    assign s0         = r_s0;
    assign s1         = r_s1;
    assign changed_s0 = r_changed_s0;
    assign changed_s1 = r_changed_s1;
    assign stable_s0  = r_stable_s0;
    assign stable_s1  = r_stable_s1;

endmodule

// File: tb/tb_grn_node_multi.sv
// Directed bench for grn_node_multi: instance A (STATE_W=2, DIV=2, CNT_W=4) and
// instance B (STATE_W=1, DIV=1, CNT_W=16) with hand-computed expectations.
module tb_grn_node_multi;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A
    logic       a_reset_nos = 0, a_start_s0 = 0, a_start_s1 = 0;
    logic [1:0] a_init = '0;
    logic [7:0] a_in_s0 = '0, a_in_s1 = '0;
    logic [3:0] a_act = '0, a_inh = '0;
    logic [1:0] a_s0, a_s1;
    logic       a_chg0, a_chg1;
    logic [3:0] a_st0, a_st1;

    // Instance B
    logic       b_reset_nos = 0, b_start_s0 = 0, b_start_s1 = 0;
    logic       b_init = 1'b0;
    logic [3:0] b_in_s0 = '0, b_in_s1 = '0;
    logic [3:0] b_act = '0, b_inh = '0;
    logic       b_s0, b_s1;
    logic       b_chg0, b_chg1;
    logic [15:0] b_st0, b_st1;

    int n_vec = 0;
    int n_err = 0;

    grn_node_multi #(.STATE_W(2), .NUM_IN(4), .DIV(2), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .reset_nos(a_reset_nos),
        .start_s0(a_start_s0), .start_s1(a_start_s1), .init_state(a_init),
        .in_s0(a_in_s0), .in_s1(a_in_s1), .act_mask(a_act), .inh_mask(a_inh),
        .s0(a_s0), .s1(a_s1), .changed_s0(a_chg0), .changed_s1(a_chg1),
        .stable_s0(a_st0), .stable_s1(a_st1)
    );

    grn_node_multi #(.STATE_W(1), .NUM_IN(4), .DIV(1), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst(rst), .reset_nos(b_reset_nos),
        .start_s0(b_start_s0), .start_s1(b_start_s1), .init_state(b_init),
        .in_s0(b_in_s0), .in_s1(b_in_s1), .act_mask(b_act), .inh_mask(b_inh),
        .s0(b_s0), .s1(b_s1), .changed_s0(b_chg0), .changed_s1(b_chg1),
        .stable_s0(b_st0), .stable_s1(b_st1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_reload(input logic [1:0] v);
        a_init = v;
        a_reset_nos = 1'b1;
        tick();
        a_reset_nos = 1'b0;
    endtask

    task automatic a_pulse_s0();
        a_start_s0 = 1'b1;
        tick();
        a_start_s0 = 1'b0;
    endtask

    task automatic a_pulse_s1();
        a_start_s1 = 1'b1;
        tick();
        a_start_s1 = 1'b0;
    endtask

    logic [1:0] exp_s1_t2 [3] = '{2'd2, 2'd3, 2'd3};
    logic       exp_ch_t2 [3] = '{1'b1, 1'b1, 1'b0};
    logic [3:0] exp_st_t2 [3] = '{4'd0, 4'd0, 4'd1};
    logic [1:0] exp_s0_t3 [4] = '{2'd1, 2'd1, 2'd2, 2'd2};

    initial begin
        tick();
        tick();
        check("rst_a_s0", 32'(a_s0), 0);
        check("rst_a_st1", 32'(a_st1), 0);
        check("rst_b_s1", 32'(b_s1), 0);
        rst = 1'b0;
        tick();

        // Activation climbs to the ceiling of a 2-bit state, then saturates.
        a_act   = 4'b0011;
        a_inh   = 4'b0000;
        a_in_s1 = 8'h05;
        a_reload(2'd1);
        check("t2_reload", 32'(a_s1), 1);
        for (int i = 0; i < 3; i++) begin
            a_pulse_s1();
            check($sformatf("t2_s1_%0d", i), 32'(a_s1), 32'(exp_s1_t2[i]));
            check($sformatf("t2_chg_%0d", i), 32'(a_chg1), 32'(exp_ch_t2[i]));
            check($sformatf("t2_st_%0d", i), 32'(a_st1), 32'(exp_st_t2[i]));
        end
        tick();
        check("t2_chg_idle", 32'(a_chg1), 0);

        // Divide-by-2: only pulses 1 and 3 evaluate s0.
        a_in_s0 = 8'h05;
        a_reload(2'd0);
        for (int i = 0; i < 4; i++) begin
            a_pulse_s0();
            check($sformatf("t3_s0_%0d", i), 32'(a_s0), 32'(exp_s0_t3[i]));
            if (i == 1) begin
                check("t3_chg_skip", 32'(a_chg0), 0);
                check("t3_st_skip", 32'(a_st0), 0);
            end
            tick();
        end

        // Drive s0 to 3 and stable_s1 to 5, then assert rst mid-cycle.
        a_in_s1    = 8'h00;
        a_start_s0 = 1'b1;
        a_start_s1 = 1'b1;
        tick();
        a_start_s0 = 1'b0;
        check("t1_chg0", 32'(a_chg0), 1);
        for (int i = 0; i < 4; i++) tick();
        a_start_s1 = 1'b0;
        check("t1_pre_s0", 32'(a_s0), 3);
        check("t1_pre_st1", 32'(a_st1), 5);
        rst = 1'b1;
        #1;
        check("t1_async_s0", 32'(a_s0), 0);
        check("t1_async_st1", 32'(a_st1), 0);
        check("t1_async_chg0", 32'(a_chg0), 0);
        #1;
        rst = 1'b0;
        tick();

        // Leave phase at 1, then reload simultaneous with both strobes.
        a_pulse_s0();
        check("t4_pre_s0", 32'(a_s0), 1);
        a_in_s1     = 8'h05;
        a_init      = 2'd2;
        a_reset_nos = 1'b1;
        a_start_s0  = 1'b1;
        a_start_s1  = 1'b1;
        tick();
        a_reset_nos = 1'b0;
        a_start_s0  = 1'b0;
        a_start_s1  = 1'b0;
        check("t4_s0", 32'(a_s0), 2);
        check("t4_s1", 32'(a_s1), 2);
        check("t4_chg0", 32'(a_chg0), 0);
        check("t4_chg1", 32'(a_chg1), 0);
        check("t4_st0", 32'(a_st0), 0);
        check("t4_st1", 32'(a_st1), 0);
        a_pulse_s0();
        check("t4_phase_cleared", 32'(a_s0), 3);

        // Tie (2 activators vs 2 inhibitors) held for 20 strobes; 4-bit counter saturates.
        a_inh   = 4'b1100;
        a_in_s1 = 8'h55;
        a_reload(2'd1);
        a_start_s1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("t5_s1_%0d", i), 32'(a_s1), 1);
            check($sformatf("t5_st_%0d", i), 32'(a_st1), (i < 15) ? i + 1 : 15);
            check($sformatf("t5_chg_%0d", i), 32'(a_chg1), 0);
        end
        a_start_s1 = 1'b0;

        // STATE_W=1, DIV=1: s1 inhibited to floor, s0 activated at ceiling.
        b_act   = 4'b0001;
        b_inh   = 4'b1110;
        b_in_s0 = 4'b0001;
        b_in_s1 = 4'b1111;
        b_init  = 1'b1;
        b_reset_nos = 1'b1;
        tick();
        b_reset_nos = 1'b0;
        b_start_s0 = 1'b1;
        b_start_s1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t6_s1_%0d", i), 32'(b_s1), 0);
            check($sformatf("t6_chg1_%0d", i), 32'(b_chg1), (i == 0) ? 1 : 0);
            check($sformatf("t6_st1_%0d", i), 32'(b_st1), i);
            check($sformatf("t6_s0_%0d", i), 32'(b_s0), 1);
            check($sformatf("t6_st0_%0d", i), 32'(b_st0), i + 1);
        end
        b_start_s0 = 1'b0;
        b_start_s1 = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
